load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the toy CPU execute stage and the 4096x16 data memory. It drives that memory's `rd`/`wr`/`mem_access_addr`/`wd` inputs and consumes its combinational `Rd` output. It turns single-cycle CPU requests into memory port cycles. A small write buffer lets stores retire without stalling, and loads return one registered response each.

## Interface
- `ADDR_W`, 12: word address width; matches the data memory depth of 4096.
- `DATA_W`, 16: data word width.
- `WB_DEPTH`, 4: write-buffer entries; power of two, at least 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `resp_valid`  out  1  one-cycle pulse carrying load data; no backpressure.
- `resp_rdata`  out  DATA_W  load data; holds its value between pulses.
- `mem_rd`  out  1  to data memory `rd`.
- `mem_wr`  out  1  to data memory `wr`.
- `mem_addr`  out  ADDR_W  to data memory `mem_access_addr`.
- `mem_wd`  out  DATA_W  to data memory `wd`.
- `mem_rdata`  in  DATA_W  from data memory `Rd`; combinational and valid in the same cycle as `mem_rd`.
- `wb_empty`  out  1  write buffer holds no entries.

## Operation
- The FSM has four states: IDLE, DRAIN, READ, RESP.
- Write buffer: a circular FIFO of {addr, data}, with head/tail pointers and a count of width log2(WB_DEPTH)+1. Stores enter at the tail and leave from the head.
- `req_ready` = (state==IDLE) && !(req_we && wb_full). The full check uses the count before any same-cycle pop.
- Store accepted in IDLE: push at the tail. The state stays IDLE. No response is generated.
- Drain: in IDLE or DRAIN with the buffer non-empty, pop the head. In that cycle `mem_wr`=1, `mem_addr`=head addr, `mem_wd`=head data, and memory commits at the rising edge. A push and a pop in the same cycle are both performed and the count is unchanged.
- Load accepted in IDLE: latch the address, then:
  - with a forwarding hit (see Configuration), latch the data and go to RESP;
  - with no hit and the buffer empty, go to READ;
  - otherwise go to DRAIN.
- DRAIN: pop one entry per cycle. `req_ready`=0. Move to READ in the cycle after the last pop, i.e. when the count is 0.
- READ: `mem_rd`=1, `mem_addr`=latched address, `mem_wr`=0, and there is no pop. Capture `mem_rdata` into `resp_rdata`, then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE. Draining continues in RESP if entries are present. `req_ready`=0.
- When neither a read nor a pop is active: `mem_rd`=`mem_wr`=0 and `mem_addr`=`mem_wd`=0.
- Reset values: state IDLE, buffer emptied, `resp_valid`=0, `resp_rdata`=0, all `mem_*` outputs 0, `wb_empty`=1. `req_ready`=1 in the first cycle after reset.
- Reset mid-operation discards the buffer contents and any pending load. No response pulse is produced. Stores not yet drained are lost, by design.

## Timing
- A store takes 1 cycle to accept. It reaches memory no earlier than the rising edge ending the cycle after acceptance.
- Load with a forwarding hit: accepted in cycle N, `resp_valid` in N+1.
- Load miss, buffer empty: accepted in N, READ in N+1, `resp_valid` in N+2.
- Load miss without forwarding, k entries buffered: READ in N+1+k, `resp_valid` in N+2+k. Pushes and pops during the accept cycle adjust k.
- The next request can be accepted in the cycle after `resp_valid`.

## Configuration
- `LSU_FWD_EN` defined: a load in IDLE searches all valid entries. The youngest entry whose address matches wins, and its data is forwarded. On a miss the unit goes straight to READ even if the buffer is non-empty, and the drain pauses for that cycle.
- `LSU_FWD_EN` undefined: there is no search. Every load with a non-empty buffer goes through DRAIN, so memory is always coherent before READ.

## Structure
- Shared package `lsu_pkg` holds:
  - the state enum `lsu_state_t` (IDLE, DRAIN, READ, RESP);
  - default width constants ADDR_W=12 and DATA_W=16;
  - the `wb_entry_t` struct {addr, data}.
- Sub-module `lsu_write_buffer` contains:
  - the FIFO storage, pointers and count;
  - the full and empty flags;
  - under `LSU_FWD_EN`, the youngest-match search (hit flag plus data).
- The FSM and the memory-port muxing live in the top module.

## Test plan
- Reset with `mem_rdata` held at 16'hFFFF: all outputs are 0 and `wb_empty`=1. `req_ready`=1 on the first cycle after reset.
- Store (5, 16'h1234), then a load of 5 with forwarding on: `resp_valid` at N+1 with 16'h1234. With forwarding off: one drain cycle, then READ, `resp_rdata`=16'h1234 at N+3.
- Four stores back to back with WB_DEPTH=4, a drain on every cycle: the count never exceeds the limit. A fifth store while the count is 4 and a pop is active sees `req_ready`=0.
- Stores to 7 of 16'hAAAA then 16'hBBBB, then a load of 7 with forwarding: the youngest match returns 16'hBBBB.
- Memory preloaded with addr 9 = 16'h00C3, buffer empty: a load of 9 drives `mem_rd`=1 and `mem_addr`=9 in N+1, and returns 16'h00C3 at N+2.
- Assert `rst` during DRAIN with 3 entries buffered: no `mem_wr` and no `resp_valid` afterwards, `wb_empty`=1, and the memory contents at those addresses are unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/lsu_write_buffer.sv
// Circular store buffer of {addr, data}; pushes at the tail, pops from the head.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: full/empty flags only; pushes while full and pops while empty are ignored.
//
// Ports: clk, rst (sync, active-high); push/push_addr/push_data; pop;
//        head_addr/head_data (oldest entry); full, empty.
// Optional: LSU_FWD_EN adds lookup_addr -> fwd_hit/fwd_data (youngest matching entry).
module lsu_write_buffer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
`ifdef LSU_FWD_EN
  ,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          slots [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = slots[head].addr;
  assign head_data = slots[head].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots between head and tail are ever read as valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[tail] <= '{addr: push_addr, data: push_data};
  end

`ifdef LSU_FWD_EN
  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (slots[head + PW'(i)].addr == lookup_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = slots[head + PW'(i)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU execute stage and the 4096x16 data memory.
// Latency: store accept 1 cycle; load 2 cycles on an empty buffer, +k drain cycles, 1 on a forward hit.
// Backpressure: req_ready drops outside IDLE and for stores while the buffer is full; resp has none.
//
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_we/req_addr/req_wdata;
//        resp_valid/resp_rdata; mem_rd/mem_wr/mem_addr/mem_wd/mem_rdata; wb_empty.
// Optional: define LSU_FWD_EN to forward buffered store data to loads.
module load_store_unit #(
  parameter int ADDR_W   = lsu_pkg::ADDR_W,
  parameter int DATA_W   = lsu_pkg::DATA_W,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_empty
);

  import lsu_pkg::*;

  lsu_state_t        state;
  logic [ADDR_W-1:0] ld_addr;
  logic              wb_full;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              accept;
  logic              push;
  logic              load_acc;
  logic              pop;
  logic              read_cyc;
`ifdef LSU_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Full check deliberately ignores a same-cycle pop.
  assign req_ready = (state == IDLE) && !(req_we && wb_full);
  assign accept    = req_valid && req_ready;
  assign push      = accept && req_we;
  assign load_acc  = accept && !req_we;
  // Reset holds the memory port quiet so buffered stores are dropped, never committed.
  assign pop       = !rst && !wb_empty && (state != READ);
  assign read_cyc  = !rst && (state == READ);

  lsu_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WB_DEPTH)
  ) u_wb (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (req_addr),
    .push_data (req_wdata),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (wb_full),
    .empty     (wb_empty)
`ifdef LSU_FWD_EN
    ,
    .lookup_addr (req_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data)
`endif
  );

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (read_cyc) begin
      mem_rd   = 1'b1;
      mem_addr = ld_addr;
    end else if (pop) begin
      mem_wr   = 1'b1;
      mem_addr = head_addr;
      mem_wd   = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_addr    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc) begin
            ld_addr <= req_addr;
`ifdef LSU_FWD_EN
            // A miss cannot alias any buffered store, so memory is safe to read now.
            if (fwd_hit) begin
              resp_rdata <= fwd_data;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= READ;
            end
`else
            // Emptiness is judged before this cycle's pop.
            state <= wb_empty ? READ : DRAIN;
`endif
          end
        end
        DRAIN: begin
          if (wb_empty) state <= READ;
        end
        READ: begin
          resp_rdata <= mem_rdata;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory model.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen high.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rdata;
  logic          wb_empty;

  logic [DW-1:0] dmem [4096];   // the data memory the unit talks to
  logic [DW-1:0] cm   [4096];   // model: committed memory contents
  bit            force_ff = 1'b1;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  typedef struct { wb_entry_t e; int acc; } pend_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } exp_t;
  pend_t store_q[$];            // accepted stores not yet committed, program order
  exp_t  exp_q[$];              // expected load responses

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW), .WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pv(int a);
    logic [31:0] t;
    if (a == 9)  return 16'h00C3;
    if (a == 20) return 16'h0F0F;
    t = a * 32'h301 + 32'h1000;
    return t[15:0];
  endfunction

  // Memory with combinational read port.
  assign mem_rdata = force_ff ? 16'hFFFF : dmem[mem_addr];
  initial begin
    for (int a = 0; a < 4096; a++) dmem[a] = pv(a);
    forever begin
      @(posedge clk);
      if (mem_wr) dmem[mem_addr] <= mem_wd;
    end
  end

  function automatic void chk(bit ok, string name, longint act, longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected load value: youngest pending store to the address, else committed memory.
  // Latency: forwarding hit 1, otherwise 2 plus any drain of buffered stores.
  function automatic void record(bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    pend_t         p;
    exp_t          x;
    bit            hit;
    int            lat;
    logic [DW-1:0] v;
    if (we) begin
      p.e.addr = a;
      p.e.data = d;
      p.acc    = cyc;
      store_q.push_back(p);
    end else begin
      hit = 1'b0;
      v   = cm[a];
      foreach (store_q[i]) begin
        if (store_q[i].e.addr == a) begin
          hit = 1'b1;
          v   = store_q[i].e.data;
        end
      end
`ifdef LSU_FWD_EN
      lat = hit ? 1 : 2;
`else
      lat = 2 + store_q.size();
`endif
      x.addr = a;
      x.data = v;
      x.due  = cyc + lat;
      exp_q.push_back(x);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        record(we, a, d);
        done = 1'b1;
      end else if (++waits > 64) begin
        chk(1'b0, "accept_timeout", waits, 64);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Monitor: checks the memory port and responses against the model every cycle.
  initial begin
    for (int a = 0; a < 4096; a++) cm[a] = pv(a);
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        chk(!mem_wr && !mem_rd, "rst_mem_quiet", {mem_rd, mem_wr}, 0);
        store_q.delete();
        exp_q.delete();
      end else begin
        int pend;
        pend = 0;
        foreach (store_q[i]) if (store_q[i].acc < cyc) pend++;
        chk(wb_empty == (pend == 0), "wb_empty", wb_empty, pend == 0);
        chk(pend <= DEPTH, "wb_count", pend, DEPTH);
        if (mem_wr) begin
          chk(!mem_rd, "rd_wr_both", mem_rd, 0);
          if (store_q.size() == 0) begin
            chk(1'b0, "wr_unexpected", mem_addr, 0);
          end else begin
            pend_t p;
            p = store_q.pop_front();
            chk(mem_addr == p.e.addr, "wr_addr", mem_addr, p.e.addr);
            chk(mem_wd == p.e.data, "wr_data", mem_wd, p.e.data);
            chk(p.acc < cyc, "wr_too_early", cyc, p.acc + 1);
            cm[p.e.addr] = p.e.data;
          end
        end else if (mem_rd) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "rd_unexpected", mem_addr, 0);
          end else begin
            chk(mem_addr == exp_q[0].addr, "rd_addr", mem_addr, exp_q[0].addr);
            chk(cyc == exp_q[0].due - 1, "rd_cycle", cyc, exp_q[0].due - 1);
          end
        end else begin
          chk(mem_addr == '0 && mem_wd == '0, "bus_idle", {mem_addr, mem_wd}, 0);
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "resp_spurious", resp_rdata, 0);
          end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk(resp_rdata == x.data, "resp_data", resp_rdata, x.data);
            chk(cyc == x.due, "resp_cycle", cyc, x.due);
          end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
          chk(1'b0, "resp_timeout", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  drained;
    // Reset state with the memory read port driving all ones.
    rst = 1'b1;
    force_ff = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(resp_valid == 1'b0, "rst_resp_valid", resp_valid, 0);
    chk(resp_rdata == '0, "rst_resp_rdata", resp_rdata, 0);
    chk({mem_rd, mem_wr} == 2'b00, "rst_mem_ctl", {mem_rd, mem_wr}, 0);
    chk({mem_addr, mem_wd} == '0, "rst_mem_bus", {mem_addr, mem_wd}, 0);
    chk(wb_empty == 1'b1, "rst_wb_empty", wb_empty, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(req_ready == 1'b1, "ready_after_rst", req_ready, 1);
    chk(resp_rdata == '0, "rdata_after_rst", resp_rdata, 0);
    chk(wb_empty == 1'b1, "empty_after_rst", wb_empty, 1);
    @(posedge clk); #1;
    force_ff = 1'b0;

    // Store then load of the same word.
    issue(1'b1, 12'd5, 16'h1234, w);
    issue(1'b0, 12'd5, 16'h0000, w);
    idle(8);

    // Two stores to one word: the younger value must be returned.
    issue(1'b1, 12'd7, 16'hAAAA, w);
    issue(1'b1, 12'd7, 16'hBBBB, w);
    issue(1'b0, 12'd7, 16'h0000, w);
    idle(8);

    // Load from preloaded memory with an empty buffer.
    issue(1'b0, 12'd9, 16'h0000, w);
    idle(6);

    // Back-to-back stores are each accepted in one cycle.
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 12'(40 + i), 16'(16'hC000 + i), w);
      chk(w == 0, "store_back_to_back", w, 0);
    end
    issue(1'b0, 12'd44, 16'h0000, w);
    idle(8);

    // Reset right after a store: it must never reach memory.
    issue(1'b1, 12'd20, 16'h5555, w);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
    @(negedge clk);
    chk(dmem[20] == 16'h0F0F, "lost_store_mem", dmem[20], 16'h0F0F);
    chk(wb_empty == 1'b1, "lost_store_empty", wb_empty, 1);
    @(posedge clk); #1;

    // Reset with a load in flight: no response pulse may follow.
    issue(1'b0, 12'd9, 16'h0000, w);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);

    // Reset while a load waits behind a store.
    issue(1'b1, 12'd21, 16'h7777, w);
    issue(1'b0, 12'd22, 16'h0000, w);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);

    // Random mix of loads and stores over a small address window.
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 99) < 55, 12'($urandom_range(48, 63)), 16'($urandom), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    drained = 1'b0;
    for (int i = 0; i < 200 && !drained; i++) begin
      @(negedge clk);
      if (store_q.size() == 0 && exp_q.size() == 0) drained = 1'b1;
    end
    chk(drained, "final_drain", store_q.size() + exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    for (int a = 0; a < 64; a++) begin
      chk(dmem[a] == cm[a], "mem_final", dmem[a], cm[a]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
